// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : IF/ID layout constants and fetch-state encoding
// Revision     : 1.0
// ============================================================================
package pipeline_pkg;

  localparam int IFID_W         = 96;
  localparam int IFID_PC_MSB    = 95;
  localparam int IFID_PC_LSB    = 32;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_INSTR_LSB = 0;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// ifid_pipe_reg : IF/ID register with flush > load > hold-on-stop > bubble
// Revision      : 1.0
// ============================================================================
module ifid_pipe_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                load_i,
  input  logic                stop_i,
  input  logic [63:0]         pc_i,
  input  logic [31:0]         instr_i,
  output logic [IFID_W-1:0]   ifid_o,
  output logic                valid_o
);

  logic [IFID_W-1:0] ifid_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q  <= {64'h0, BUBBLE_INSTR};
      valid_q <= 1'b0;
    end else if (flush_i) begin
      ifid_q  <= {64'h0, BUBBLE_INSTR};
      valid_q <= 1'b0;
    end else if (load_i) begin
      ifid_q[IFID_PC_MSB:IFID_PC_LSB]       <= pc_i;
      ifid_q[IFID_INSTR_MSB:IFID_INSTR_LSB] <= instr_i;
      valid_q                               <= 1'b1;
    end else if (!stop_i) begin
      // Empty cycle without a stall: decode sees a bubble tagged with the pc
      ifid_q[IFID_PC_MSB:IFID_PC_LSB]       <= pc_i;
      ifid_q[IFID_INSTR_MSB:IFID_INSTR_LSB] <= BUBBLE_INSTR;
      valid_q                               <= 1'b0;
    end
  end

  assign ifid_o  = ifid_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// instruction_fetch_stage : PC owner, single-outstanding imem fetch, IF/ID load
// Revision                : 1.0
// ============================================================================
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stop,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [95:0] ifid_register,
  output logic        ifid_valid
);

  import pipeline_pkg::*;

  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  logic         drop_q;
  logic         req_valid_q;
  logic [31:0]  hold_buf_q;

  logic         w_accept;
  logic         w_rsp;
  logic         w_load;
  logic [31:0]  w_load_instr;
  logic [63:0]  w_redirect_pc;

  assign w_accept      = req_valid_q & imem_req_ready;
  assign w_rsp         = (state_q == WAIT) & imem_rsp_valid;
  assign w_redirect_pc = redirect_pc & ~64'd3;
  assign pc_d          = pc_q + 64'd4;

  assign w_load = ~redirect_valid & ~stop &
                  ((w_rsp & ~drop_q) | (state_q == HOLD));
  assign w_load_instr = (state_q == HOLD) ? hold_buf_q : imem_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      hold_buf_q  <= 32'h0;
    end else if (redirect_valid) begin
      pc_q       <= w_redirect_pc;
      hold_buf_q <= 32'h0;
      case (state_q)
        FETCH: begin
          if (w_accept) begin
            // The request just accepted targets the old path
            state_q     <= WAIT;
            drop_q      <= 1'b1;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_q     <= FETCH;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b1;
          end else begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= FETCH;
          drop_q      <= 1'b0;
          req_valid_q <= 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (w_accept) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              state_q     <= FETCH;
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
            end else if (stop) begin
              state_q    <= HOLD;
              hold_buf_q <= imem_rsp_data;
            end else begin
              state_q     <= FETCH;
              pc_q        <= pc_d;
              req_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stop) begin
            state_q     <= FETCH;
            pc_q        <= pc_d;
            req_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= FETCH;
          drop_q      <= 1'b0;
          req_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;

  ifid_pipe_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .load_i  (w_load),
    .stop_i  (stop),
    .pc_i    (pc_q),
    .instr_i (w_load_instr),
    .ifid_o  (ifid_register),
    .valid_o (ifid_valid)
  );

endmodule
`default_nettype wire

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front stage of the 5-stage RV64 pipeline.
- Owns the PC and fetches 32-bit instructions over a request/response instruction-memory port (one request outstanding at a time).
- Loads the IF/ID pipeline register consumed by the decode stage.
- Honours the hazard stall (`stop`) and the branch/jump redirect from execute.

Parameters:
- RESET_PC, 64'h0, PC fetched first after reset release.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) written into IF/ID on flush or empty cycles.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- stop  input  1  hazard stall; IF/ID and PC hold while high
- redirect_valid  input  1  taken branch/jump from execute
- redirect_pc  input  64  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request when valid&ready
- imem_addr  output  64  fetch address (= pc)
- imem_rsp_valid  input  1  response valid, never earlier than cycle after acceptance
- imem_rsp_data  input  32  fetched instruction
- ifid_register  output  96  {pc[63:0] at [95:32], instruction[31:0] at [31:0]}
- ifid_valid  output  1  ifid_register holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, drop=0, hold buffer cleared.
  - ifid_register={64'h0,NOP_INSTR}, ifid_valid=0.
  - imem_req_valid=0 while in reset.
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc. On valid&ready go to WAIT; otherwise stay.
  - WAIT: imem_req_valid=0; await imem_rsp_valid.
    - On response with drop=0 and stop=0: ifid<={pc,data}, ifid_valid<=1, pc<=pc+4, go to FETCH.
    - On response with drop=0 and stop=1: capture data in hold buffer, go to HOLD.
    - On response with drop=1: discard data, clear drop, go to FETCH.
  - HOLD: imem_req_valid=0. When stop=0: ifid<={pc,buffer}, ifid_valid<=1, pc<=pc+4, go to FETCH.
- IF/ID update rule when no instruction is delivered this cycle:
  - stop=1: hold ifid_register and ifid_valid.
  - stop=0: load bubble {pc,NOP_INSTR}, ifid_valid=0.
- Redirect (redirect_valid=1), highest priority after reset, wins over stop:
  - pc<={redirect_pc[63:2],2'b00}.
  - IF/ID flushed to bubble ({64'h0,NOP_INSTR}, valid=0) this edge.
  - FETCH with request accepted same cycle: go to WAIT with drop=1.
  - FETCH with no handshake: stay in FETCH at the new pc.
  - WAIT: set drop=1 (if a response arrives the same cycle, it is the dropped one: discard it and go to FETCH).
  - HOLD: discard buffer, go to FETCH.
- Latency and throughput:
  - Request accepted at cycle N, response at N+k (k≥1): ifid_valid is seen high after the edge ending cycle N+k.
  - Peak throughput is one instruction per 2 cycles.
- Arithmetic: pc+4 is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.
- imem_addr and imem_req_valid are registered/stable while in FETCH and not accepted; the address must not change unless a redirect occurs.
- Unexpected imem_rsp_valid in FETCH/HOLD is ignored (assertion in bench).

Decomposition:
- Shared package (pipeline_pkg) holds:
  - IFID_W=96, the IFID_PC_MSB/LSB and IFID_INSTR_MSB/LSB field constants, NOP_INSTR.
  - The fetch state enum {FETCH,WAIT,HOLD}.
  - The decode stage reuses the same layout constants.
- One sub-module, ifid_pipe_reg: 96-bit register plus valid, with load/hold/flush controls. Priority: reset > flush > load > hold-on-stop > bubble.

Test Plan:
- Reset release, imem ready always, rsp 1 cycle later with 32'h00500093 → first request addr 0; ifid={64'h0,32'h00500093}, valid=1; next addr 4.
- stop=1 asserted while in WAIT, rsp 32'h00208133 arrives → ifid unchanged, state HOLD; stop drop → ifid={pc,32'h00208133}, then request at pc+4.
- redirect_valid with redirect_pc=64'h1003 during WAIT, stale rsp next cycle → stale data never reaches IF/ID; ifid bubble valid=0; next request addr 64'h1000.
- redirect and stop both high with valid IF/ID contents → IF/ID flushed to {0,NOP}, valid=0; pc=target.
- imem_req_ready low for 3 cycles in FETCH → imem_addr stable, ifid bubbles (valid=0) each cycle stop=0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → after first fetch the next request addr is 64'h0; rst_n asserted mid-WAIT → outputs return to reset values immediately, pending rsp ignored.
